// File: rtl/arb_pkg.sv
// Shared types and sizing for the round-robin arbiter and its picker.
package arb_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;
    localparam int ARB_N     = 8;
    localparam int ARB_IDX_W = $clog2(ARB_N);
endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first set request at or after the pointer.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = ARB_N,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_pick_oh,
    output logic [IW-1:0] o_pick_idx
);
    logic [2*N-1:0] w_dbl;
    logic           w_found;

    assign w_dbl = {i_req, i_req};

    // The upper copy covers the wrap-around, so a linear scan from ptr is circular.
    always_comb begin
        w_found    = 1'b0;
        o_pick_oh  = '0;
        o_pick_idx = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!w_found && (i >= int'(i_ptr)) && w_dbl[i]) begin
                w_found          = 1'b1;
                o_pick_idx       = IW'(i % N);
                o_pick_oh[i % N] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter with registered one-hot grant, done/abandon/timeout release.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int N       = ARB_N,
    parameter int TIMEOUT = 16,
    localparam int IW     = $clog2(N)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [N-1:0] req,
    input  logic        done,
    output logic [N-1:0] gnt,
    output logic        gnt_valid,
    output logic        timeout,
    output arb_state_t  dbg_state
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    arb_state_t      r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]    r_gnt;
    logic            r_gnt_valid;
    logic            r_timeout;
    logic [N-1:0]    w_pick_oh;
    logic [IW-1:0]   w_pick_idx;
    logic [IW-1:0]   w_ptr_next;
    logic            w_tmo_hit;

    rr_pick #(.N(N)) u_pick (
        .i_req      (req),
        .i_ptr      (r_ptr),
        .o_pick_oh  (w_pick_oh),
        .o_pick_idx (w_pick_idx)
    );

    assign w_ptr_next = (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;
    assign w_tmo_hit  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt       <= w_pick_oh;
                        r_owner     <= w_pick_idx;
                        r_gnt_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    // Release priority: done, then abandoned request, then timeout.
                    if (done || !req[r_owner] || w_tmo_hit) begin
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= IDLE;
                        r_timeout   <= !done && req[r_owner];
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;
    assign dbg_state = r_state;
endmodule
